// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its lane logic.
package dmem_arb_pkg;
    localparam int WORD_BYTES_2POW = 3;
    localparam int OFFSET_BITS     = WORD_BYTES_2POW;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ADDR  = 3'd1,
        LD_CAP   = 3'd2,
        RMW_ADDR = 3'd3,
        RMW_CAP  = 3'd4,
        ST_WR    = 3'd5,
        RESP     = 3'd6
    } state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshake and DataMemory signals around dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // Request i transfers on a rising edge where reqValid_in[i] and reqReady_out[i] are both 1;
    // the requester holds its fields stable while valid and not ready.
    logic [1:0]            reqValid_in;
    logic [1:0]            reqReady_out;
    logic [ADDR_WIDTH-1:0] reqAddress0_in;
    logic [ADDR_WIDTH-1:0] reqAddress1_in;
    logic [1:0]            reqWrite_in;
    logic [1:0]            reqSize0_in;
    logic [1:0]            reqSize1_in;
    logic [1:0]            reqUnsigned_in;
    logic [DATA_WIDTH-1:0] reqData0_in;
    logic [DATA_WIDTH-1:0] reqData1_in;
    logic [1:0]            rspValid_out;
    logic [1:0]            rspError_out;
    logic [DATA_WIDTH-1:0] rspData_out;
    logic [ADDR_WIDTH-1:0] memAddress_out;
    logic [DATA_WIDTH-1:0] memData_out;
    logic                  memWriteEnable_out;
    logic                  memReadEnable_out;
    logic [DATA_WIDTH-1:0] memData_in;

    modport slave (
        input  reqValid_in, reqAddress0_in, reqAddress1_in, reqWrite_in,
               reqSize0_in, reqSize1_in, reqUnsigned_in, reqData0_in, reqData1_in,
               memData_in,
        output reqReady_out, rspValid_out, rspError_out, rspData_out,
               memAddress_out, memData_out, memWriteEnable_out, memReadEnable_out
    );

    modport master (
        output reqValid_in, reqAddress0_in, reqAddress1_in, reqWrite_in,
               reqSize0_in, reqSize1_in, reqUnsigned_in, reqData0_in, reqData1_in,
               memData_in,
        input  reqReady_out, rspValid_out, rspError_out, rspData_out,
               memAddress_out, memData_out, memWriteEnable_out, memReadEnable_out
    );
endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, alignment check.
module dmem_lane_merge
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]  word_in,
    input  logic [OFFSET_BITS-1:0] offset_in,
    input  size_e                  size_in,
    input  logic                   unsigned_in,
    input  logic [DATA_WIDTH-1:0]  store_data_in,
    output logic [DATA_WIDTH-1:0]  load_data_out,
    output logic [DATA_WIDTH-1:0]  merged_out,
    input  logic [OFFSET_BITS-1:0] chk_offset_in,
    input  size_e                  chk_size_in,
    output logic                   misaligned_out
);
    logic [OFFSET_BITS+2:0] shamt;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   sext;
    logic [7:0]             byte_mask_raw;
    logic [7:0]             byte_mask;
    logic [DATA_WIDTH-1:0]  bit_mask;

    always_comb begin
        shamt   = {offset_in, 3'b000};
        shifted = word_in >> shamt;
        sext    = 1'b0;
        case (size_in)
            SIZE_B: begin
                sext          = ~unsigned_in & shifted[7];
                load_data_out = {{(DATA_WIDTH-8){sext}}, shifted[7:0]};
            end
            SIZE_H: begin
                sext          = ~unsigned_in & shifted[15];
                load_data_out = {{(DATA_WIDTH-16){sext}}, shifted[15:0]};
            end
            SIZE_W: begin
                sext          = ~unsigned_in & shifted[31];
                load_data_out = {{(DATA_WIDTH-32){sext}}, shifted[31:0]};
            end
            default: load_data_out = shifted;
        endcase
    end

    // Byte-enable mask placed at the lane offset, expanded to a bit mask for the merge.
    always_comb begin
        case (size_in)
            SIZE_B:  byte_mask_raw = 8'h01;
            SIZE_H:  byte_mask_raw = 8'h03;
            SIZE_W:  byte_mask_raw = 8'h0F;
            default: byte_mask_raw = 8'hFF;
        endcase
        byte_mask = byte_mask_raw << offset_in;
        bit_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
        end
        merged_out = (word_in & ~bit_mask) | ((store_data_in << shamt) & bit_mask);
    end

    always_comb begin
        case (chk_size_in)
            SIZE_B:  misaligned_out = 1'b0;
            SIZE_H:  misaligned_out = chk_offset_in[0];
            SIZE_W:  misaligned_out = |chk_offset_in[1:0];
            default: misaligned_out = |chk_offset_in;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter that sequences sized loads/stores onto a 64-bit DataMemory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic           clk_in,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output state_e         state_dbg_out
);
    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    size_e                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  err_q, err_d;

    logic                  gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    size_e                 sel_size;
    logic                  sel_write;
    logic                  sel_uns;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_misaligned;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;
    logic [1:0]            ready;
    logic [1:0]            rsp_valid;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        gnt       = (bus.reqValid_in == 2'b11) ? ~last_grant_q : bus.reqValid_in[1];
        sel_addr  = gnt ? bus.reqAddress1_in : bus.reqAddress0_in;
        sel_size  = size_e'(gnt ? bus.reqSize1_in : bus.reqSize0_in);
        sel_write = bus.reqWrite_in[gnt];
        sel_uns   = bus.reqUnsigned_in[gnt];
        sel_data  = gnt ? bus.reqData1_in : bus.reqData0_in;
    end

    dmem_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .word_in        (bus.memData_in),
        .offset_in      (addr_q[OFFSET_BITS-1:0]),
        .size_in        (size_q),
        .unsigned_in    (uns_q),
        .store_data_in  (wdata_q),
        .load_data_out  (load_data),
        .merged_out     (merged),
        .chk_offset_in  (sel_addr[OFFSET_BITS-1:0]),
        .chk_size_in    (sel_size),
        .misaligned_out (sel_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_q;
        err_d        = err_q;
        ready        = 2'b00;
        case (state_q)
            IDLE: begin
                if (|bus.reqValid_in) begin
                    ready[gnt]   = 1'b1;
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    addr_d       = sel_addr;
                    size_d       = sel_size;
                    uns_d        = sel_uns;
                    wdata_d      = sel_data;
                    rsp_data_d   = '0;
                    err_d        = sel_misaligned;
                    if (sel_misaligned)           state_d = RESP;
                    else if (!sel_write)          state_d = LD_ADDR;
                    else if (sel_size == SIZE_D)  state_d = ST_WR;
                    else                          state_d = RMW_ADDR;
                end
            end
            LD_ADDR:  state_d = LD_CAP;
            LD_CAP: begin
                rsp_data_d = load_data;
                state_d    = RESP;
            end
            RMW_ADDR: state_d = RMW_CAP;
            RMW_CAP: begin
                wdata_d = merged;
                state_d = ST_WR;
            end
            ST_WR:    state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
        end
    end

    assign rsp_valid              = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.reqReady_out       = ready;
    assign bus.rspValid_out       = rsp_valid;
    assign bus.rspError_out       = rsp_valid & {2{err_q}};
    assign bus.rspData_out        = rsp_data_q;
    assign bus.memAddress_out     = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign bus.memData_out        = wdata_q;
    assign bus.memReadEnable_out  = (state_q == LD_ADDR) || (state_q == RMW_ADDR);
    assign bus.memWriteEnable_out = (state_q == ST_WR);
    assign state_dbg_out          = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a one-cycle-latency DataMemory model.
module tb_dmem_arbiter
    import dmem_arb_pkg::*;
;
    localparam int EXP_W = 102;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    state_e      state_dbg;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;

    logic        req_valid [2];
    logic        req_wr    [2];
    logic        req_uns   [2];
    logic [1:0]  req_size  [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_data  [2];

    logic [EXP_W-1:0] exp_q[$];
    int               gnt_log[$];

    logic [63:0] mem [128];
    logic [63:0] mem_rd = 64'd0;
    logic [63:0] last_wr = 64'd0;
    logic        mem_clear = 1'b1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    dmem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk_in        (clk),
        .reset         (rst),
        .bus           (bus),
        .state_dbg_out (state_dbg)
    );

    assign bus.reqValid_in    = {req_valid[1], req_valid[0]};
    assign bus.reqWrite_in    = {req_wr[1], req_wr[0]};
    assign bus.reqUnsigned_in = {req_uns[1], req_uns[0]};
    assign bus.reqSize0_in    = req_size[0];
    assign bus.reqSize1_in    = req_size[1];
    assign bus.reqAddress0_in = req_addr[0];
    assign bus.reqAddress1_in = req_addr[1];
    assign bus.reqData0_in    = req_data[0];
    assign bus.reqData1_in    = req_data[1];
    assign bus.memData_in     = mem_rd;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // DataMemory model: read data appears the cycle after the read-enabled address
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 64'd0;
            mem[1] <= 64'h0123_4567_89AB_CDEF;
        end else begin
            if (bus.memReadEnable_out) mem_rd <= mem[bus.memAddress_out[9:3]];
            if (bus.memWriteEnable_out) begin
                mem[bus.memAddress_out[9:3]] <= bus.memData_out;
                last_wr <= bus.memData_out;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // driver: present one request and wait (bounded) for its acceptance
    task automatic drive_req(input int r, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [63:0] addr, input logic [63:0] data,
                             input bit expect_rsp, input bit err, input bit chk,
                             input logic [63:0] exp_data, input int lat);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_wr[r]    = wr;
        req_size[r]  = sz;
        req_uns[r]   = uns;
        req_addr[r]  = addr;
        req_data[r]  = data;
        req_valid[r] = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (bus.reqReady_out[r]) begin
                got = 1'b1;
                gnt_log.push_back(r);
                if (expect_rsp) exp_q.push_back({r[0], err, chk, lat[2:0], cyc, exp_data});
                @(posedge clk);
                #1;
                req_valid[r] = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: requester %0d never saw ready", r);
            req_valid[r] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && state_dbg == IDLE) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d state=%0d", exp_q.size(), state_dbg);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic [1:0]       onehot;
        if (bus.memReadEnable_out) rd_cnt++;
        if (bus.memWriteEnable_out) wr_cnt++;
        if (bus.memReadEnable_out && bus.memWriteEnable_out) begin
            checks++;
            errors++;
            $display("FAIL mem_enable_overlap: read and write both high at cycle %0d", cyc);
        end
        if (!rst && bus.rspValid_out != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rspValid=%b with nothing expected", bus.rspValid_out);
            end else begin
                e      = exp_q.pop_front();
                onehot = e[101] ? 2'b10 : 2'b01;
                check("rsp_owner", 64'(bus.rspValid_out), 64'(onehot));
                check("rsp_error", 64'(bus.rspError_out), e[100] ? 64'(onehot) : 64'd0);
                if (e[99]) check("rsp_data", bus.rspData_out, e[63:0]);
                check("rsp_latency", 64'(cyc - e[95:64]), 64'(e[98:96]));
            end
        end
    end

    initial begin
        int rd0, wr0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_uns[i] = 1'b0;
            req_size[i] = 2'd0; req_addr[i] = 64'd0; req_data[i] = 64'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        check("reset_ready", 64'(bus.reqReady_out), 64'd0);
        check("reset_rsp_valid", 64'(bus.rspValid_out), 64'd0);
        check("reset_rsp_error", 64'(bus.rspError_out), 64'd0);
        check("reset_rsp_data", bus.rspData_out, 64'd0);
        check("reset_mem_addr", bus.memAddress_out, 64'd0);
        check("reset_mem_data", bus.memData_out, 64'd0);
        check("reset_mem_en", 64'({bus.memReadEnable_out, bus.memWriteEnable_out}), 64'd0);
        mem_clear = 1'b0;
        rst = 1'b0;

        // double store then double load
        drive_req(0, 1, 2'd3, 0, 64'h10, 64'h1122_3344_5566_7788, 1, 0, 0, 64'd0, 2);
        drive_req(0, 0, 2'd3, 0, 64'h10, 64'd0, 1, 0, 1, 64'h1122_3344_5566_7788, 3);
        wait_idle();
        check("mem_word_0x10", mem[2], 64'h1122_3344_5566_7788);

        // sub-word stores (read-modify-write) and sized loads
        drive_req(0, 1, 2'd3, 0, 64'h18, 64'd0, 1, 0, 0, 64'd0, 2);
        drive_req(0, 1, 2'd0, 0, 64'h1B, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 0, 64'd0, 4);
        wait_idle();
        check("rmw_byte_wdata", last_wr, 64'h0000_0000_8000_0000);
        drive_req(0, 0, 2'd0, 0, 64'h1B, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 3);
        drive_req(0, 0, 2'd0, 1, 64'h1B, 64'd0, 1, 0, 1, 64'h0000_0000_0000_0080, 3);
        drive_req(0, 1, 2'd1, 0, 64'h1C, 64'h1234_5678_9ABC_BEEF, 1, 0, 0, 64'd0, 4);
        wait_idle();
        check("rmw_half_wdata", last_wr, 64'h0000_BEEF_8000_0000);
        drive_req(0, 0, 2'd2, 0, 64'h18, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 3);
        drive_req(0, 0, 2'd2, 1, 64'h1C, 64'd0, 1, 0, 1, 64'h0000_0000_0000_BEEF, 3);
        drive_req(0, 0, 2'd1, 0, 64'h1C, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_BEEF, 3);
        wait_idle();

        // misaligned requests from requester 1: no memory traffic
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive_req(1, 0, 2'd1, 0, 64'h21, 64'd0, 1, 1, 1, 64'd0, 1);
        drive_req(1, 1, 2'd2, 0, 64'h12, 64'hDEAD_BEEF, 1, 1, 1, 64'd0, 1);
        wait_idle();
        check("misaligned_no_read", 64'(rd_cnt - rd0), 64'd0);
        check("misaligned_no_write", 64'(wr_cnt - wr0), 64'd0);

        // tie-break alternation with both requesters continuously valid
        gnt_log.delete();
        fork
            begin
                drive_req(0, 0, 2'd3, 0, 64'h10, 64'd0, 1, 0, 1, 64'h1122_3344_5566_7788, 3);
                drive_req(0, 0, 2'd3, 0, 64'h10, 64'd0, 1, 0, 1, 64'h1122_3344_5566_7788, 3);
            end
            begin
                drive_req(1, 0, 2'd3, 0, 64'h18, 64'd0, 1, 0, 1, 64'h0000_BEEF_8000_0000, 3);
                drive_req(1, 0, 2'd3, 0, 64'h18, 64'd0, 1, 0, 1, 64'h0000_BEEF_8000_0000, 3);
            end
        join
        wait_idle();
        check("tie_grant_count", 64'(gnt_log.size()), 64'd4);
        if (gnt_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("tie_grant_order", 64'(gnt_log[i]), 64'(i % 2));
        end

        // reset during RMW_CAP of a byte store to 0x08
        wr0 = wr_cnt;
        drive_req(0, 1, 2'd0, 0, 64'h08, 64'h0000_0000_0000_00AA, 0, 0, 0, 64'd0, 0);
        for (int k = 0; k < 10 && state_dbg != RMW_CAP; k++) @(negedge clk);
        check("reached_rmw_cap", 64'(state_dbg), 64'(RMW_CAP));
        rst = 1'b1;
        #1;
        check("midrst_state", 64'(state_dbg), 64'(IDLE));
        check("midrst_mem_en", 64'({bus.memReadEnable_out, bus.memWriteEnable_out}), 64'd0);
        check("midrst_rsp_valid", 64'(bus.rspValid_out), 64'd0);
        check("midrst_mem_data", bus.memData_out, 64'd0);
        check("midrst_mem_addr", bus.memAddress_out, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_no_write", 64'(wr_cnt - wr0), 64'd0);
        check("midrst_word_0x08", mem[1], 64'h0123_4567_89AB_CDEF);
        gnt_log.delete();
        fork
            drive_req(0, 0, 2'd3, 0, 64'h08, 64'd0, 1, 0, 1, 64'h0123_4567_89AB_CDEF, 3);
            drive_req(1, 0, 2'd0, 1, 64'h0F, 64'd0, 1, 0, 1, 64'h0000_0000_0000_0001, 3);
        join
        wait_idle();
        check("postrst_grant_count", 64'(gnt_log.size()), 64'd2);
        if (gnt_log.size() == 2) begin
            check("postrst_first_grant", 64'(gnt_log[0]), 64'd0);
            check("postrst_second_grant", 64'(gnt_log[1]), 64'd1);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
